// File: rtl/core_seq.sv
// rtl/core_seq.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeouts and trap reporting
module core_seq #(
  parameter int                   CPU_WIDTH = 64,
  parameter int                   INS_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RST_PC    = 'h8000_0000,
  parameter int                   TIMEOUT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_if_valid,
  output logic [CPU_WIDTH-1:0] o_if_addr,
  input  logic                 i_if_ready,
  input  logic                 i_if_rvalid,
  input  logic [INS_WIDTH-1:0] i_if_rdata,
  output logic [INS_WIDTH-1:0] o_ins,
  output logic [CPU_WIDTH-1:0] o_pc,
  input  logic                 i_is_mem,
  input  logic                 i_is_ebreak,
  input  logic                 i_rdwen,
  input  logic [CPU_WIDTH-1:0] i_next_pc,
  input  logic                 i_a0zero,
  output logic                 o_ls_valid,
  input  logic                 i_ls_ready,
  input  logic                 i_ls_rvalid,
  output logic                 o_rd_wen,
  output logic                 o_commit,
  output logic [CPU_WIDTH-1:0] o_retired,
  output logic                 o_halt,
  output logic                 o_good_trap,
  output logic [1:0]           o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [INS_WIDTH-1:0] NOP = INS_WIDTH'(32'h0000_0013);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_IWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
  } state_t;

  state_t        state;
  logic [TW-1:0] tmo;
  logic          tmo_hit;

  // Last waiting cycle: the counter has already seen TIMEOUT-1 cycles in this state.
  assign tmo_hit   = (tmo == TW'(TIMEOUT - 1));
  assign o_if_addr = o_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_RESET;
      tmo         <= '0;
      o_pc        <= RST_PC;
      o_ins       <= NOP;
      o_if_valid  <= 1'b0;
      o_ls_valid  <= 1'b0;
      o_rd_wen    <= 1'b0;
      o_commit    <= 1'b0;
      o_retired   <= '0;
      o_halt      <= 1'b0;
      o_good_trap <= 1'b0;
      o_err       <= 2'd0;
    end else begin
      o_commit <= 1'b0;
      o_rd_wen <= 1'b0;
      tmo      <= tmo + TW'(1);
      case (state)
        S_RESET: begin
          state      <= S_FETCH;
          o_if_valid <= 1'b1;
          tmo        <= '0;
        end
        S_FETCH: begin
          if (i_if_ready) begin
            state      <= S_IWAIT;
            o_if_valid <= 1'b0;
            tmo        <= '0;
          end else if (tmo_hit) begin
            state      <= S_HALT;
            o_if_valid <= 1'b0;
            o_halt     <= 1'b1;
            o_err      <= 2'd1;
          end
        end
        S_IWAIT: begin
          if (i_if_rvalid) begin
            o_ins <= i_if_rdata;
            state <= S_DECODE;
          end else if (tmo_hit) begin
            state  <= S_HALT;
            o_halt <= 1'b1;
            o_err  <= 2'd1;
          end
        end
        S_DECODE: begin
          if (i_is_ebreak) begin
            state       <= S_HALT;
            o_halt      <= 1'b1;
            o_good_trap <= i_a0zero;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (i_is_mem) begin
            state      <= S_MEM;
            o_ls_valid <= 1'b1;
            tmo        <= '0;
          end else begin
            state    <= S_WB;
            o_commit <= 1'b1;
            o_rd_wen <= i_rdwen;
          end
        end
        S_MEM: begin
          if (i_ls_ready) begin
            state      <= S_MWAIT;
            o_ls_valid <= 1'b0;
            tmo        <= '0;
          end else if (tmo_hit) begin
            state      <= S_HALT;
            o_ls_valid <= 1'b0;
            o_halt     <= 1'b1;
            o_err      <= 2'd1;
          end
        end
        S_MWAIT: begin
          if (i_ls_rvalid) begin
            state    <= S_WB;
            o_commit <= 1'b1;
            o_rd_wen <= i_rdwen;
          end else if (tmo_hit) begin
            state  <= S_HALT;
            o_halt <= 1'b1;
            o_err  <= 2'd1;
          end
        end
        S_WB: begin
          o_retired <= o_retired + CPU_WIDTH'(1);
          // A misaligned target still retires this instruction, but the PC keeps its value.
          if (i_next_pc[1:0] != 2'b00) begin
            state  <= S_HALT;
            o_halt <= 1'b1;
            o_err  <= 2'd2;
          end else begin
            o_pc       <= i_next_pc;
            state      <= S_FETCH;
            o_if_valid <= 1'b1;
            tmo        <= '0;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// tb/tb_core_seq.sv - scoreboard bench for core_seq bus handshakes, traps, timeouts and reset
module tb_core_seq;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] LD     = 32'h0000_2103;
  localparam logic [31:0] SW     = 32'h0020_a023;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        o_if_valid;
  logic [63:0] o_if_addr;
  logic        i_if_ready;
  logic        i_if_rvalid;
  logic [31:0] i_if_rdata;
  logic [31:0] o_ins;
  logic [63:0] o_pc;
  logic        i_is_mem;
  logic        i_is_ebreak;
  logic        i_rdwen;
  logic [63:0] i_next_pc;
  logic        i_a0zero;
  logic        o_ls_valid;
  logic        i_ls_ready;
  logic        i_ls_rvalid;
  logic        o_rd_wen;
  logic        o_commit;
  logic [63:0] o_retired;
  logic        o_halt;
  logic        o_good_trap;
  logic [1:0]  o_err;

  always #5 clk = ~clk;

  core_seq dut (
    .i_clk(clk), .i_rst(i_rst),
    .o_if_valid(o_if_valid), .o_if_addr(o_if_addr), .i_if_ready(i_if_ready),
    .i_if_rvalid(i_if_rvalid), .i_if_rdata(i_if_rdata), .o_ins(o_ins), .o_pc(o_pc),
    .i_is_mem(i_is_mem), .i_is_ebreak(i_is_ebreak), .i_rdwen(i_rdwen),
    .i_next_pc(i_next_pc), .i_a0zero(i_a0zero), .o_ls_valid(o_ls_valid),
    .i_ls_ready(i_ls_ready), .i_ls_rvalid(i_ls_rvalid), .o_rd_wen(o_rd_wen),
    .o_commit(o_commit), .o_retired(o_retired), .o_halt(o_halt),
    .o_good_trap(o_good_trap), .o_err(o_err)
  );

  typedef struct {
    logic [63:0] pc;
    logic        rdw;
    logic [63:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_commit = 0;
  int          n_rdwen = 0;
  logic [63:0] exp_pc;
  logic [63:0] exp_ret;
  logic [31:0] prev_ins;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Commit monitor: every retirement must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_rd_wen) n_rdwen++;
      if (o_commit) begin
        exp_t e;
        n_commit++;
        chk("sb_pending", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("commit_pc", o_pc, e.pc);
          chk("commit_rd_wen", o_rd_wen, e.rdw);
          chk("commit_retired", o_retired, e.ret);
        end
      end else begin
        chk("rd_wen_idle", o_rd_wen, 1'b0);
      end
    end
  end

  task automatic do_reset(input bit check_drain);
    if (check_drain) chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    i_rst = 1'b1;
    i_if_ready = 0; i_if_rvalid = 0; i_if_rdata = 32'hdead_beef;
    i_is_mem = 0; i_is_ebreak = 0; i_rdwen = 0; i_next_pc = '0; i_a0zero = 0;
    i_ls_ready = 0; i_ls_rvalid = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc", o_pc, RST_PC);
    chk("rst_ins", o_ins, NOP);
    chk("rst_retired", o_retired, 0);
    chk("rst_err", o_err, 0);
    chk("rst_flags", {o_if_valid, o_ls_valid, o_rd_wen, o_commit, o_halt, o_good_trap}, 0);
    exp_pc = RST_PC; exp_ret = 0; prev_ins = NOP;
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one instruction from FETCH to its end; entry and exit are at a negedge.
  task automatic do_ins(input logic [31:0] ins, input bit mem, input bit ebrk, input bit rdw,
                        input bit a0z, input logic [63:0] npc,
                        input int ird, input int irv, input int lrd, input int lrv);
    int cyc = 0;
    int rd0 = n_rdwen;
    exp_t e;
    i_is_mem = mem; i_is_ebreak = ebrk; i_rdwen = rdw; i_a0zero = a0z; i_next_pc = npc;
    for (int k = 0; k <= ird; k++) begin
      chk("if_valid", o_if_valid, 1'b1);
      chk("if_addr", o_if_addr, exp_pc);
      i_if_ready  = (k == ird);
      i_if_rvalid = 1'b1;
      i_if_rdata  = 32'hdead_beef;
      @(negedge clk); cyc++;
    end
    i_if_ready = 1'b0;
    for (int k = 0; k <= irv; k++) begin
      chk("iwait_ins_hold", o_ins, prev_ins);
      chk("iwait_if_valid", o_if_valid, 1'b0);
      i_if_rvalid = (k == irv);
      i_if_rdata  = (k == irv) ? ins : 32'hbad0_0000 | 32'(k);
      if (k == irv && !ebrk) begin
        e.pc = exp_pc; e.rdw = rdw; e.ret = exp_ret;
        sb.push_back(e);
      end
      @(negedge clk); cyc++;
    end
    i_if_rvalid = 1'b0;
    i_if_rdata  = 32'hdead_beef;
    chk("decode_ins", o_ins, ins);
    prev_ins = ins;
    @(negedge clk); cyc++;
    if (ebrk) begin
      chk("ebrk_halt", o_halt, 1'b1);
      chk("ebrk_good_trap", o_good_trap, a0z);
      chk("ebrk_err", o_err, 0);
      return;
    end
    @(negedge clk); cyc++;
    if (mem) begin
      for (int k = 0; k <= lrd; k++) begin
        chk("mem_ls_valid", o_ls_valid, 1'b1);
        i_ls_ready  = (k == lrd);
        i_ls_rvalid = 1'b1;
        @(negedge clk); cyc++;
      end
      i_ls_ready = 1'b0;
      for (int k = 0; k <= lrv; k++) begin
        chk("mwait_ls_valid", o_ls_valid, 1'b0);
        i_ls_rvalid = (k == lrv);
        @(negedge clk); cyc++;
      end
      i_ls_rvalid = 1'b0;
    end
    chk("wb_commit", o_commit, 1'b1);
    @(negedge clk); cyc++;
    chk("latency", 64'(cyc), 64'(5 + ird + irv + (mem ? 2 + lrd + lrv : 0)));
    chk("rd_wen_pulses", 64'(n_rdwen - rd0), 64'(rdw));
    exp_ret++;
    chk("retired", o_retired, exp_ret);
    if (npc[1:0] != 2'b00) begin
      chk("mis_halt", o_halt, 1'b1);
      chk("mis_err", o_err, 2);
      chk("mis_pc_kept", o_pc, exp_pc);
    end else begin
      exp_pc = npc;
      chk("next_pc", o_pc, exp_pc);
    end
  endtask

  task automatic hold_halted(input int n);
    for (int i = 0; i < n; i++) begin
      i_if_ready = 1'b1; i_if_rvalid = 1'b1; i_ls_ready = 1'b1; i_ls_rvalid = 1'b1;
      @(negedge clk);
      chk("halt_sticky", {o_halt, o_if_valid, o_ls_valid}, 3'b100);
    end
    i_if_ready = 0; i_if_rvalid = 0; i_ls_ready = 0; i_ls_rvalid = 0;
  endtask

  initial begin
    int c0;
    do_reset(1'b0);

    for (int i = 0; i < 3; i++) do_ins(ADDI, 0, 0, 1, 0, exp_pc + 4, 0, 0, 0, 0);
    chk("retired_after_3", o_retired, 3);

    c0 = n_commit;
    do_ins(ADDI, 0, 0, 1, 0, exp_pc + 4, 4, 3, 0, 0);
    chk("single_commit", 64'(n_commit - c0), 1);

    do_ins(LD, 1, 0, 1, 0, exp_pc + 4, 0, 0, 2, 2);
    do_ins(SW, 1, 0, 0, 0, exp_pc + 4, 1, 0, 0, 1);
    do_ins(ADDI, 0, 0, 1, 0, 64'h8000_1000, 0, 0, 0, 0);

    c0 = n_commit;
    do_ins(EBRK, 0, 1, 0, 1, exp_pc + 4, 0, 0, 0, 0);
    hold_halted(4);
    chk("ebrk_no_commit", 64'(n_commit - c0), 0);

    do_reset(1'b1);
    do_ins(ADDI, 0, 0, 1, 0, exp_pc + 4, 0, 0, 0, 0);
    c0 = n_commit;
    do_ins(EBRK, 0, 1, 0, 0, exp_pc + 4, 0, 0, 0, 0);
    hold_halted(2);
    chk("ebrk0_no_commit", 64'(n_commit - c0), 0);

    do_reset(1'b1);
    i_if_ready = 1'b1;
    @(negedge clk);
    i_if_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("tmo_halt", o_halt, (i == 16));
    end
    chk("tmo_err", o_err, 1);
    chk("tmo_good_trap", o_good_trap, 0);
    hold_halted(2);

    do_reset(1'b1);
    do_ins(ADDI, 0, 0, 1, 0, exp_pc + 4, 0, 0, 0, 0);
    do_ins(ADDI, 0, 0, 1, 0, 64'h8000_0002, 0, 0, 0, 0);
    hold_halted(2);
    chk("mis_err_hold", o_err, 2);

    do_reset(1'b1);
    do_ins(ADDI, 0, 0, 1, 0, exp_pc + 4, 0, 0, 0, 0);
    i_is_mem = 1; i_rdwen = 1; i_is_ebreak = 0; i_next_pc = exp_pc + 4;
    i_if_ready = 1'b1;
    @(negedge clk);
    i_if_ready = 1'b0; i_if_rvalid = 1'b1; i_if_rdata = LD;
    @(negedge clk);
    i_if_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mwrst_ls_valid", o_ls_valid, 1'b1);
    i_ls_ready = 1'b1;
    @(negedge clk);
    i_ls_ready = 1'b0;
    chk("mwrst_in_mwait", {o_ls_valid, o_if_valid}, 0);
    c0 = n_commit;
    i_rst = 1'b1; i_ls_rvalid = 1'b1;
    @(negedge clk);
    chk("mwrst_rd_wen", o_rd_wen, 1'b0);
    chk("mwrst_commit", o_commit, 1'b0);
    chk("mwrst_pc", o_pc, RST_PC);
    chk("mwrst_retired", o_retired, 0);
    chk("mwrst_no_commit", 64'(n_commit - c0), 0);
    do_reset(1'b1);
    do_ins(ADDI, 0, 0, 1, 0, exp_pc + 4, 0, 0, 0, 0);
    chk("sb_final", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
